stopwatch_timer_fsm: RTL
========================

// Module: stopwatch_timer_fsm
// PURPOSE
//   Parametrised stopwatch/countdown-timer controller with an NUM_DIGITS-digit BCD counter.
//   Four modes: stopwatch from zero, stopwatch from preset, timer from max, timer from preset.
//   Adds lap/split display hold, an optional wrap-around stopwatch and edge-detected buttons,
//   so no separate press/release states are needed.
//   Sits between the board switch/button inputs and the seven-segment display driver.
// PARAMETERS
//   NUM_DIGITS     4  BCD digits in the count; all-9s is the maximum.
//   PRESET_DIGITS  2  Upper digits loaded from preset; lower digits load as 0. Must be <= NUM_DIGITS.
//   WRAP_UP        0  1: stopwatch wraps all-9s -> 0 and keeps running, never DONE.
// PORTS
//   clk          in   1                One clock; all logic rising-edge.
//   reset        in   1                Asynchronous, active-low.
//   tick         in   1                1-cycle count-enable pulse, one per 0.01 s.
//   clr          in   1                Synchronous clear: go to LOAD.
//   btn_start    in   1                Clean level; only the rising edge acts.
//   btn_lap      in   1                Clean level; only the rising edge acts.
//   mode         in   2                00 SW/0, 01 SW/preset, 10 TMR/max, 11 TMR/preset.
//   preset       in   4*PRESET_DIGITS  BCD preset digits.
//   count        out  4*NUM_DIGITS     Live BCD count.
//   display      out  4*NUM_DIGITS     Shows count, or the held lap value while lap_active.
//   running      out  1                High in RUN.
//   done         out  1                High in DONE.
//   lap_active   out  1                Display hold engaged.
//   state_dbg    out  3                State encoding, for debug.
// BEHAVIOUR
//   Reset (async, reset=0):
//     state=IDLE; count, display, done, running, lap_active = 0; edge regs = 0.
//   Button edges: press = btn & ~btn_q, where btn_q is a 1-cycle registered copy.
//   States:
//     IDLE -start-> LOAD.
//     LOAD: count <= start value every cycle, re-sampling mode/preset; -start-> RUN.
//     RUN -start-> PAUSE; RUN -terminal-> DONE.
//     PAUSE -start-> RUN.
//     DONE: holds until clr.
//   Start value:
//     mode 00 -> 0; mode 10 -> all-9s.
//     mode x1 -> preset in the upper digits, 0 below.
//     Any preset nibble > 9 -> start value is all-9s.
//   Counting: only in RUN with tick=1. Up for mode 0x, down for mode 1x. BCD ripple carry/borrow.
//   Terminal:
//     Up reaching all-9s -> DONE on the same edge, unless WRAP_UP=1 (next tick -> 0).
//     Down reaching 0 -> DONE on the same edge.
//     done is registered: high in the cycle after the tick that reached the terminal value.
//   Already-terminal start value: LOAD -start-> DONE directly, count unchanged.
//   Lap:
//     In RUN, a btn_lap press toggles the hold.
//     Engaging the hold latches count into the hold register that day cycle; display freezes on it.
//     In PAUSE, a lap press releases the hold.
//     Entering DONE or LOAD clears the hold.
//     Lap presses in IDLE, LOAD and DONE are ignored.
//   Priority, same cycle: clr > start press > terminal/tick > lap.
//     start press and tick together in RUN: go to PAUSE, tick discarded.
//   mode/preset changes outside LOAD have no effect until the next LOAD.
//   clr in any state, including IDLE: LOAD next cycle, hold cleared.
//   reset mid-count: immediate async return to IDLE.
// STRUCTURE
//   Package stopwatch_pkg:
//     state enum {IDLE, LOAD, RUN, PAUSE, DONE}.
//     Mode codes MODE_SW0, MODE_SWP, MODE_TMRMAX, MODE_TMRP.
//     BCD_NINE = 4'd9.
//   Sub-module bcd_updown_counter #(NUM_DIGITS):
//     Inputs: load, load_val, en, up.
//     Outputs: q, at_max, at_zero.
//     Per-digit carry/borrow chain.
//   The FSM, edge detectors and lap register stay in this module.
// TESTING
//   1. mode=00, start x2, 150 ticks -> count=0x0150, running=1; start -> PAUSE; extra ticks leave count 0x0150.
//   2. mode=11, preset=0x12, start x2, 1200 ticks -> count=0x0000, done=1 the next cycle; later ticks ignored.
//   3. mode=01, preset=0x9A (invalid) -> LOAD count=0x9999; start -> DONE at once (WRAP_UP=0);
//      with WRAP_UP=1: running, next tick -> 0x0000.
//   4. RUN at 0x0042, lap press -> display=0x0042 held while count advances;
//      second lap press -> display tracks count.
//   5. start press and tick in the same cycle at 0x0007 -> PAUSE, count stays 0x0007;
//      clr and start together -> LOAD.
//   6. Assert reset mid-RUN, between clock edges -> all outputs 0 and state IDLE before the next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state, mode and BCD definitions for the stopwatch/timer controller.
package stopwatch_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
   localparam logic [1:0] MODE_SW0    = 2'b00;
   localparam logic [1:0] MODE_SWP    = 2'b01;
   localparam logic [1:0] MODE_TMRMAX = 2'b10;
   localparam logic [1:0] MODE_TMRP   = 2'b11;
   localparam logic [3:0] BCD_NINE    = 4'd9;
endpackage

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: loadable NUM_DIGITS-digit BCD up/down counter with a per-digit carry/borrow chain.
module bcd_updown_counter
   import stopwatch_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic                    en,
   input  logic                    up,
   output logic [4*NUM_DIGITS-1:0] q,
   output logic                    at_max,
   output logic                    at_zero
);
   logic [NUM_DIGITS-1:0]   c;
   logic [4*NUM_DIGITS-1:0] nxt;
   // c[i] is the carry (up) or borrow (down) into digit i
   always_comb begin
      c = NUM_DIGITS'(1);
      for (int i = 1; i < NUM_DIGITS; i++)
         c[i] = c[i-1] & (up ? q[4*(i-1) +: 4] == BCD_NINE : q[4*(i-1) +: 4] == 4'd0);
      nxt = q;
      at_max = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (c[i])
            nxt[4*i +: 4] = up ? (q[4*i +: 4] == BCD_NINE ? 4'd0 : q[4*i +: 4] + 4'd1)
                               : (q[4*i +: 4] == 4'd0 ? BCD_NINE : q[4*i +: 4] - 4'd1);
         at_max &= q[4*i +: 4] == BCD_NINE;
      end
   end
   assign at_zero = q == '0;
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         q <= '0;
      else if (load)
         q <= load_val;
      else if (en)
         q <= nxt;
endmodule

// File: rtl/stopwatch_timer_fsm.sv
// stopwatch_timer_fsm: stopwatch/countdown controller with BCD count, lap display hold
// and edge-detected start/lap buttons.
module stopwatch_timer_fsm
   import stopwatch_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int PRESET_DIGITS = 2,
   parameter bit WRAP_UP       = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick,
   input  logic                       clr,
   input  logic                       btn_start,
   input  logic                       btn_lap,
   input  logic [1:0]                 mode,
   input  logic [4*PRESET_DIGITS-1:0] preset,
   output logic [4*NUM_DIGITS-1:0]    count,
   output logic [4*NUM_DIGITS-1:0]    display,
   output logic                       running,
   output logic                       done,
   output logic                       lap_active,
   output logic [2:0]                 state_dbg
);
   localparam int W = 4*NUM_DIGITS;
   localparam logic [W-1:0] ALL9    = {NUM_DIGITS{BCD_NINE}};
   localparam logic [W-1:0] UP_LAST = ALL9 - W'(1);
   localparam logic [W-1:0] DN_LAST = W'(1);

   state_t         state, nxt;
   logic           start_q, lap_q, start_p, lap_p, up_q, lap_d, at_max, at_zero, bad, term;
   logic [W-1:0]   hold, hold_d, start_val, pre_val;

   assign start_p = btn_start & ~start_q;
   assign lap_p   = btn_lap & ~lap_q;

   always_comb begin
      bad = 1'b0;
      pre_val = '0;
      for (int i = 0; i < PRESET_DIGITS; i++) begin
         bad |= preset[4*i +: 4] > BCD_NINE;
         pre_val[4*(i+NUM_DIGITS-PRESET_DIGITS) +: 4] = preset[4*i +: 4];
      end
      start_val = mode[0] ? (bad ? ALL9 : pre_val) : (mode == MODE_TMRMAX ? ALL9 : '0);
   end

   // terminal is detected one step early so DONE lands on the edge that reaches it
   assign term = tick & (up_q ? (!WRAP_UP && count == UP_LAST) : count == DN_LAST);

   always_comb begin
      nxt = state;
      lap_d = lap_active;
      hold_d = hold;
      if (clr) begin
         nxt = LOAD;
         lap_d = 1'b0;
      end else begin
         case (state)
            IDLE:  nxt = start_p ? LOAD : IDLE;
            LOAD:  nxt = !start_p ? LOAD : (up_q ? (!WRAP_UP && at_max) : at_zero) ? DONE : RUN;
            RUN:
               if (start_p)
                  nxt = PAUSE;
               else if (term) begin
                  nxt = DONE;
                  lap_d = 1'b0;
               end else if (lap_p) begin
                  lap_d = ~lap_active;
                  hold_d = lap_active ? hold : count;
               end
            PAUSE:
               if (start_p)
                  nxt = RUN;
               else if (lap_p)
                  lap_d = 1'b0;
            default: nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         lap_q      <= 1'b0;
         up_q       <= 1'b1;
         lap_active <= 1'b0;
         hold       <= '0;
      end else begin
         state      <= nxt;
         start_q    <= btn_start;
         lap_q      <= btn_lap;
         up_q       <= nxt == LOAD ? ~mode[1] : up_q;
         lap_active <= lap_d;
         hold       <= hold_d;
      end

   bcd_updown_counter #(.NUM_DIGITS(NUM_DIGITS)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (nxt == LOAD),
      .load_val (start_val),
      .en       (state == RUN && tick && !clr && !start_p),
      .up       (up_q),
      .q        (count),
      .at_max   (at_max),
      .at_zero  (at_zero)
   );

   assign display   = lap_active ? hold : count;
   assign running   = state == RUN;
   assign done      = state == DONE;
   assign state_dbg = state;
endmodule
